// File: rtl/line_arb_deadlock_monitor_gen2_pkg.sv
// Shared types and helpers for the lineArb deadlock monitor.
// Holds the FSM state encoding and the index-width helper.
package line_arb_dlmon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } dlmon_state_e;

    // Index width that never collapses to zero for single-entry vectors.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_arb_deadlock_monitor_gen2_if.sv
// Status/stimulus bundle between the monitored pipeline and the deadlock monitor.
// The slave modport is the monitor side.
interface line_arb_deadlock_monitor_gen2_if
    import line_arb_dlmon_pkg::*;
#(
    parameter int unsigned N_AXIS = 8,
    parameter int unsigned N_SUB  = 2,
    parameter int unsigned CNT_W  = 1,
    parameter int unsigned IDX_W  = clog2_min1(N_AXIS)
);
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_SUB-1:0]  inst_idle_sigs;
    logic [N_SUB-1:0]  inst_block_sigs;
    logic              clear;
    logic              block;
    logic              block_pulse;
    logic [N_AXIS-1:0] chan_mask;
    logic [IDX_W-1:0]  first_chan;
    logic              sub_cause;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_pulse, chan_mask, first_chan, sub_cause, stall_cnt
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_pulse, chan_mask, first_chan, sub_cause, stall_cnt
    );
endinterface

// File: rtl/line_arb_deadlock_monitor_gen2_prienc.sv
// Lowest-set-bit priority encoder; index is 0 when the vector is empty.
module line_arb_dlmon_prienc
    import line_arb_dlmon_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last to write.
        for (int unsigned i = N; i > 0; i--) begin
            if (vec_i[i-1]) idx_o = IDX_W'(i - 1);
        end
        valid_o = |vec_i;
    end
endmodule

// File: rtl/line_arb_deadlock_monitor_gen2.sv
// Deadlock monitor: flags a persistent stream/sub-instance block after THRESH
// consecutive cycles and captures which channels were blocked at detection.
module line_arb_deadlock_monitor_gen2
    import line_arb_dlmon_pkg::*;
#(
    parameter int unsigned N_AXIS = 8,
    parameter int unsigned N_SUB  = 2,
    parameter int unsigned THRESH = 1,
    parameter bit          STICKY = 1'b0,
    parameter int unsigned CNT_W  = $clog2(THRESH + 1),
    parameter int unsigned IDX_W  = clog2_min1(N_AXIS)
) (
    input logic                            clock,
    input logic                            reset_n,
    line_arb_deadlock_monitor_gen2_if.slave bus
);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    dlmon_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              block_q, block_d;
    logic              pulse_q, pulse_d;
    logic [N_AXIS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]  first_q, first_d;
    logic              subc_q, subc_d;

    logic              sub_blk;
    logic              raw;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_valid;

    assign sub_blk = (&(bus.inst_idle_sigs | bus.inst_block_sigs)) & (|bus.inst_block_sigs);
    assign raw     = (|bus.axis_block_sigs) | sub_blk;

    line_arb_dlmon_prienc #(
        .N     (N_AXIS),
        .IDX_W (IDX_W)
    ) u_prienc (
        .vec_i   (bus.axis_block_sigs),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        block_d = block_q;
        pulse_d = 1'b0;
        mask_d  = mask_q;
        first_d = first_q;
        subc_d  = subc_q;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            block_d = 1'b0;
            mask_d  = '0;
            first_d = '0;
            subc_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, COUNT: begin
                    if (raw) begin
                        cnt_d = (state_q == IDLE) ? CNT_W'(1) : CNT_W'(cnt_q + 1'b1);
                        if (cnt_d == THRESH_C) begin
                            state_d = BLOCKED;
                            block_d = 1'b1;
                            pulse_d = 1'b1;
                            mask_d  = bus.axis_block_sigs;
                            first_d = enc_valid ? enc_idx : '0;
                            subc_d  = sub_blk;
                        end else begin
                            state_d = COUNT;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                BLOCKED: begin
                    if (!STICKY && !raw) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        block_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    block_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            block_q <= 1'b0;
            pulse_q <= 1'b0;
            mask_q  <= '0;
            first_q <= '0;
            subc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
            pulse_q <= pulse_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            subc_q  <= subc_d;
        end
    end

    assign bus.block       = block_q;
    assign bus.block_pulse = pulse_q;
    assign bus.chan_mask   = mask_q;
    assign bus.first_chan  = first_q;
    assign bus.sub_cause   = subc_q;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_line_arb_deadlock_monitor_gen2.sv
// Directed bench for line_arb_deadlock_monitor_gen2 across three parameter sets.
module tb_line_arb_deadlock_monitor_gen2;
    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A: THRESH=1 STICKY=0, B: THRESH=4 STICKY=0, C: THRESH=3 STICKY=1
    line_arb_deadlock_monitor_gen2_if #(.N_AXIS(8), .N_SUB(2), .CNT_W(1), .IDX_W(3)) if_a ();
    line_arb_deadlock_monitor_gen2_if #(.N_AXIS(8), .N_SUB(2), .CNT_W(3), .IDX_W(3)) if_b ();
    line_arb_deadlock_monitor_gen2_if #(.N_AXIS(8), .N_SUB(2), .CNT_W(2), .IDX_W(3)) if_c ();

    line_arb_deadlock_monitor_gen2 #(.N_AXIS(8), .N_SUB(2), .THRESH(1), .STICKY(1'b0)) u_a (
        .clock(clock), .reset_n(reset_n), .bus(if_a.slave));
    line_arb_deadlock_monitor_gen2 #(.N_AXIS(8), .N_SUB(2), .THRESH(4), .STICKY(1'b0)) u_b (
        .clock(clock), .reset_n(reset_n), .bus(if_b.slave));
    line_arb_deadlock_monitor_gen2 #(.N_AXIS(8), .N_SUB(2), .THRESH(3), .STICKY(1'b1)) u_c (
        .clock(clock), .reset_n(reset_n), .bus(if_c.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        if_a.axis_block_sigs = '0; if_a.inst_idle_sigs = '0; if_a.inst_block_sigs = '0; if_a.clear = 1'b0;
        if_b.axis_block_sigs = '0; if_b.inst_idle_sigs = '0; if_b.inst_block_sigs = '0; if_b.clear = 1'b0;
        if_c.axis_block_sigs = '0; if_c.inst_idle_sigs = '0; if_c.inst_block_sigs = '0; if_c.clear = 1'b0;
        #1;
        check("rst_block",   32'(if_a.block), 0);
        check("rst_pulse",   32'(if_a.block_pulse), 0);
        check("rst_mask",    32'(if_a.chan_mask), 0);
        check("rst_first",   32'(if_a.first_chan), 0);
        check("rst_subc",    32'(if_a.sub_cause), 0);
        check("rst_cnt",     32'(if_b.stall_cnt), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // THRESH=1: single-cycle raw detects on the next edge
        if_a.axis_block_sigs = 8'h10;
        tick();
        check("a_block",  32'(if_a.block), 1);
        check("a_pulse",  32'(if_a.block_pulse), 1);
        check("a_first",  32'(if_a.first_chan), 4);
        check("a_mask",   32'(if_a.chan_mask), 32'h10);
        check("a_cnt",    32'(if_a.stall_cnt), 1);
        check("a_subc",   32'(if_a.sub_cause), 0);
        if_a.axis_block_sigs = 8'h00;
        tick();
        check("a_drop_block", 32'(if_a.block), 0);
        check("a_drop_pulse", 32'(if_a.block_pulse), 0);
        check("a_hold_mask",  32'(if_a.chan_mask), 32'h10);
        check("a_drop_cnt",   32'(if_a.stall_cnt), 0);

        // Sub-instance term: one idle, one blocked -> detect
        if_a.inst_idle_sigs = 2'b01; if_a.inst_block_sigs = 2'b10;
        tick();
        check("sub_block", 32'(if_a.block), 1);
        check("sub_cause", 32'(if_a.sub_cause), 1);
        check("sub_mask",  32'(if_a.chan_mask), 0);
        check("sub_first", 32'(if_a.first_chan), 0);
        // One instance neither idle nor blocked -> no raw
        if_a.inst_idle_sigs = 2'b00; if_a.inst_block_sigs = 2'b10;
        tick();
        check("sub_busy_block", 32'(if_a.block), 0);
        tick();
        check("sub_busy_block2", 32'(if_a.block), 0);
        check("sub_busy_pulse",  32'(if_a.block_pulse), 0);
        if_a.inst_block_sigs = 2'b00;

        // THRESH=4: 3-cycle burst, gap, 4-cycle burst
        if_b.axis_block_sigs = 8'h81;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("b_burst1_cnt",   32'(if_b.stall_cnt), 32'(i));
            check("b_burst1_block", 32'(if_b.block), 0);
        end
        if_b.axis_block_sigs = 8'h00;
        tick();
        check("b_gap_cnt",   32'(if_b.stall_cnt), 0);
        check("b_gap_block", 32'(if_b.block), 0);
        if_b.axis_block_sigs = 8'h81;
        tick(); tick(); tick();
        check("b_b2_cnt3",   32'(if_b.stall_cnt), 3);
        check("b_b2_block3", 32'(if_b.block), 0);
        tick();
        check("b_b2_block", 32'(if_b.block), 1);
        check("b_b2_pulse", 32'(if_b.block_pulse), 1);
        check("b_b2_cnt",   32'(if_b.stall_cnt), 4);
        check("b_b2_mask",  32'(if_b.chan_mask), 32'h81);
        check("b_b2_first", 32'(if_b.first_chan), 0);
        tick();
        check("b_sat_cnt",   32'(if_b.stall_cnt), 4);
        check("b_sat_pulse", 32'(if_b.block_pulse), 0);
        check("b_sat_block", 32'(if_b.block), 1);
        if_b.axis_block_sigs = 8'h00;
        tick();
        check("b_release", 32'(if_b.block), 0);

        // Clear on the cycle raw would reach THRESH
        if_b.axis_block_sigs = 8'h20;
        tick(); tick(); tick();
        if_b.clear = 1'b1;
        tick();
        check("b_clr_block", 32'(if_b.block), 0);
        check("b_clr_cnt",   32'(if_b.stall_cnt), 0);
        if_b.clear = 1'b0;
        tick(); tick(); tick();
        check("b_clr_cnt3",   32'(if_b.stall_cnt), 3);
        check("b_clr_block3", 32'(if_b.block), 0);
        tick();
        check("b_clr_block4", 32'(if_b.block), 1);
        check("b_clr_first",  32'(if_b.first_chan), 5);
        if_b.axis_block_sigs = 8'h00;
        tick();

        // STICKY=1: block survives raw dropping until clear
        if_c.axis_block_sigs = 8'h06;
        tick(); tick(); tick();
        check("c_block", 32'(if_c.block), 1);
        check("c_first", 32'(if_c.first_chan), 1);
        check("c_mask",  32'(if_c.chan_mask), 32'h06);
        if_c.axis_block_sigs = 8'h00;
        tick(); tick();
        check("c_sticky_block", 32'(if_c.block), 1);
        check("c_sticky_pulse", 32'(if_c.block_pulse), 0);
        check("c_sticky_first", 32'(if_c.first_chan), 1);
        if_c.clear = 1'b1;
        tick();
        if_c.clear = 1'b0;
        check("c_clr_block", 32'(if_c.block), 0);
        check("c_clr_mask",  32'(if_c.chan_mask), 0);
        check("c_clr_first", 32'(if_c.first_chan), 0);
        check("c_clr_cnt",   32'(if_c.stall_cnt), 0);
        check("c_clr_subc",  32'(if_c.sub_cause), 0);

        // Async reset while BLOCKED, raw held through release
        if_c.axis_block_sigs = 8'h02;
        tick(); tick(); tick();
        check("c_pre_rst_block", 32'(if_c.block), 1);
        reset_n = 1'b0;
        #1;
        check("c_rst_block", 32'(if_c.block), 0);
        check("c_rst_cnt",   32'(if_c.stall_cnt), 0);
        check("c_rst_mask",  32'(if_c.chan_mask), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("c_rel_cnt1",  32'(if_c.stall_cnt), 1);
        check("c_rel_pulse1", 32'(if_c.block_pulse), 0);
        tick();
        check("c_rel_block2", 32'(if_c.block), 0);
        tick();
        check("c_rel_block3", 32'(if_c.block), 1);
        check("c_rel_pulse3", 32'(if_c.block_pulse), 1);
        check("c_rel_first",  32'(if_c.first_chan), 1);
        tick();
        check("c_rel_pulse4", 32'(if_c.block_pulse), 0);
        check("c_rel_block4", 32'(if_c.block), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
